decode_execute_reg: RTL
=======================

// Module: decode_execute_reg
// PURPOSE
//  ID/EX pipeline register. Captures decoded operands and control from Decode and presents them to Execute.
//  Sources Rs1_E/Rs2_E/Rd_E/MemRead_E for the hazard unit; consumes its stall (load-use bubble) and flush_E (branch/jump).
//  Also honours a global freeze (memory wait) and remembers a flush requested during freeze.
// PARAMETERS
//  DATA_WIDTH  32  width of RD1/RD2/ImmExt
//  ADDR_WIDTH  32  width of PC/PCPlus4
//  CNT_WIDTH   32  width of perf counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  freeze        in   1      hold entire register (memory wait)
//  stall         in   1      load-use hazard: insert bubble into E
//  flush_E       in   1      control hazard: insert bubble into E
//  valid_D       in   1      Decode slot holds a real instruction
//  PC_D          in   ADDR   instruction PC
//  PCPlus4_D     in   ADDR   PC+4
//  RD1_D/RD2_D   in   DATA   register-file read data
//  ImmExt_D      in   DATA   extended immediate
//  Rs1_D/Rs2_D/Rd_D in 5     register indices
//  ctrl_D        in   ctrl_t RegWrite, MemRead, MemWrite, ResultSrc[1:0], ALUControl[3:0], ALUSrc, Branch, Jump
//  valid_E, PC_E, PCPlus4_E, RD1_E, RD2_E, ImmExt_E, Rs1_E, Rs2_E, Rd_E, ctrl_E  out  (same widths) registered copies
//  MemRead_E     out  1      = ctrl_E.MemRead, for the hazard unit
//  bubble_cnt    out  CNT    bubbles inserted by stall (PERF_CNT_EN only)
//  flush_cnt     out  CNT    bubbles inserted by flush (PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output and flush_pend = 0. E holds a NOP bubble.
//  - Bubble = valid_E 0, ctrl_E = CTRL_NOP (all zero), Rs1_E/Rs2_E/Rd_E = 0, all data fields = 0.
//  - Zero register indices in a bubble guarantee no spurious forwarding or stall.
//  - Internal flag flush_pend, 1 bit.
//  - Per rising edge, priority order:
//    1. freeze=1: all E outputs hold. flush_pend <= flush_pend | flush_E. stall ignored (hazard unit re-evaluates).
//    2. flush_E | flush_pend: load bubble, flush_pend <= 0.
//    3. stall: load bubble.
//    4. else: capture all *_D inputs. A bubble in D (valid_D=0) propagates unchanged; ctrl_D already NOP.
//  - Flush and stall in the same cycle: one bubble, counted as flush.
//  - Latency 1 cycle D->E. No combinational path input->output.
//  - Load-use closure: bubble clears MemRead_E, so hazard stall drops next cycle => exactly 1 bubble per load-use.
//  - Reset mid-freeze: pending flush discarded; restarts from bubble.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - bubble_cnt +1 on each edge taking path 3; flush_cnt +1 on each edge taking path 2.
//   - Both saturate at all-ones, reset to 0, do not count while frozen.
//  PERF_CNT_EN undefined: counters and ports absent; zero extra flops.
// STRUCTURE
//  pipeline_pkg:
//   - ctrl_t packed struct (field order as listed in PORTS), CTRL_NOP constant
//   - RESULTSRC_* / ALUCTRL_* encodings
//   - REG_ZERO = 5'd0
//  Sub-module sat_counter #(CNT_WIDTH): clk, rst_n, inc, count. Instanced twice under PERF_CNT_EN.
//  Rest: one always_ff with async reset plus next-state always_comb.
// TESTING
//  1. Reset: rst_n=0 mid-run -> all outputs 0 immediately (async), valid_E=0.
//  2. Capture: valid_D=1, PC_D=0x100, Rd_D=5, RD1_D=0xDEADBEEF, RegWrite=1 -> next edge E fields equal D values.
//  3. Load-use:
//     - lw x5 in E (MemRead_E=1, Rd_E=5), add x6,x5,x1 in D
//     - hazard stall=1 -> E bubble (Rd_E=0, MemRead_E=0)
//     - stall drops, add enters E one cycle later
//     - bubble_cnt=1
//  4. Flush+stall same cycle -> one bubble; flush_cnt=1, bubble_cnt unchanged.
//  5. Freeze:
//     - freeze=1 for 3 cycles, flush_E pulsed in cycle 2 -> E outputs held all 3 cycles
//     - first unfrozen edge loads bubble, flush_pend=0
//  6. Saturation (CNT_WIDTH=4, PERF_CNT_EN): 20 consecutive stalls -> bubble_cnt=4'hF, no wrap.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared control bundle, NOP constant and field encodings for the ID/EX stage
package pipeline_pkg;
  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic [3:0] ALUControl;
    logic       ALUSrc;
    logic       Branch;
    logic       Jump;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  localparam logic [1:0] RESULTSRC_ALU = 2'd0;
  localparam logic [1:0] RESULTSRC_MEM = 2'd1;
  localparam logic [1:0] RESULTSRC_PC4 = 2'd2;
  localparam logic [3:0] ALUCTRL_ADD  = 4'd0;
  localparam logic [3:0] ALUCTRL_SUB  = 4'd1;
  localparam logic [3:0] ALUCTRL_AND  = 4'd2;
  localparam logic [3:0] ALUCTRL_OR   = 4'd3;
  localparam logic [3:0] ALUCTRL_XOR  = 4'd4;
  localparam logic [3:0] ALUCTRL_SLT  = 4'd5;
  localparam logic [3:0] ALUCTRL_SLTU = 4'd6;
  localparam logic [3:0] ALUCTRL_SLL  = 4'd7;
  localparam logic [3:0] ALUCTRL_SRL  = 4'd8;
  localparam logic [3:0] ALUCTRL_SRA  = 4'd9;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/decode_execute_reg_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (inc && !(&r_count)) r_count <= r_count + 1'b1;
  assign count = r_count;
endmodule

// File: rtl/decode_execute_reg.sv
// decode_execute_reg: ID/EX pipeline register with freeze, stall/flush bubbles and a remembered flush.
// PERF_CNT_EN adds saturating bubble/flush counters; undefined, no counter logic exists.
module decode_execute_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
`ifdef PERF_CNT_EN
  ,parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  stall,
  input  logic                  flush_E,
  input  logic                  valid_D,
  input  logic [ADDR_WIDTH-1:0] PC_D,
  input  logic [ADDR_WIDTH-1:0] PCPlus4_D,
  input  logic [DATA_WIDTH-1:0] RD1_D,
  input  logic [DATA_WIDTH-1:0] RD2_D,
  input  logic [DATA_WIDTH-1:0] ImmExt_D,
  input  logic [4:0]            Rs1_D,
  input  logic [4:0]            Rs2_D,
  input  logic [4:0]            Rd_D,
  input  ctrl_t                 ctrl_D,
  output logic                  valid_E,
  output logic [ADDR_WIDTH-1:0] PC_E,
  output logic [ADDR_WIDTH-1:0] PCPlus4_E,
  output logic [DATA_WIDTH-1:0] RD1_E,
  output logic [DATA_WIDTH-1:0] RD2_E,
  output logic [DATA_WIDTH-1:0] ImmExt_E,
  output logic [4:0]            Rs1_E,
  output logic [4:0]            Rs2_E,
  output logic [4:0]            Rd_E,
  output ctrl_t                 ctrl_E,
  output logic                  MemRead_E
`ifdef PERF_CNT_EN
  ,output logic [CNT_WIDTH-1:0] bubble_cnt
  ,output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);
  logic                  r_valid, r_flush_pend;
  logic [ADDR_WIDTH-1:0] r_pc, r_pc4;
  logic [DATA_WIDTH-1:0] r_rd1, r_rd2, r_imm;
  logic [4:0]            r_rs1, r_rs2, r_rd;
  ctrl_t                 r_ctrl;
  logic                  w_flush, w_stall;
  // a flush wins over a simultaneous stall so the bubble is counted once, as a flush
  always_comb begin
    w_flush = !freeze && (flush_E || r_flush_pend);
    w_stall = !freeze && !w_flush && stall;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_pc4        <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs1        <= REG_ZERO;
      r_rs2        <= REG_ZERO;
      r_rd         <= REG_ZERO;
      r_ctrl       <= CTRL_NOP;
    end else begin
      r_flush_pend <= freeze && (r_flush_pend || flush_E);
      if (w_flush || w_stall) begin
        r_valid <= 1'b0;
        r_pc    <= '0;
        r_pc4   <= '0;
        r_rd1   <= '0;
        r_rd2   <= '0;
        r_imm   <= '0;
        r_rs1   <= REG_ZERO;
        r_rs2   <= REG_ZERO;
        r_rd    <= REG_ZERO;
        r_ctrl  <= CTRL_NOP;
      end else if (!freeze) begin
        r_valid <= valid_D;
        r_pc    <= PC_D;
        r_pc4   <= PCPlus4_D;
        r_rd1   <= RD1_D;
        r_rd2   <= RD2_D;
        r_imm   <= ImmExt_D;
        r_rs1   <= Rs1_D;
        r_rs2   <= Rs2_D;
        r_rd    <= Rd_D;
        r_ctrl  <= ctrl_D;
      end
    end
  end
  assign valid_E   = r_valid;
  assign PC_E      = r_pc;
  assign PCPlus4_E = r_pc4;
  assign RD1_E     = r_rd1;
  assign RD2_E     = r_rd2;
  assign ImmExt_E  = r_imm;
  assign Rs1_E     = r_rs1;
  assign Rs2_E     = r_rs2;
  assign Rd_E      = r_rd;
  assign ctrl_E    = r_ctrl;
  assign MemRead_E = r_ctrl.MemRead;
`ifdef PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (.clk(clk), .rst_n(rst_n), .inc(w_stall), .count(bubble_cnt));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt  (.clk(clk), .rst_n(rst_n), .inc(w_flush), .count(flush_cnt));
`endif
endmodule
